// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES forward/inverse S-box lanes walk a
// BLOCK_BYTES state in NBEATS cycles, with valid/ready on both sides.

package sub_bytes_pkg;
   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0 as AES requires)
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r, sq;
      r  = 8'h01;
      sq = x;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) r = gf_mul(r, sq);
         sq = gf_mul(sq, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction
endpackage

// Forward S-box: field inverse followed by the affine transform
module sbox (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);
   import sub_bytes_pkg::*;
   logic [7:0] t;
   assign t   = gf_inv(a_i);
   assign y_o = t ^ rotl(t, 1) ^ rotl(t, 2) ^ rotl(t, 3) ^ rotl(t, 4) ^ 8'h63;
endmodule

// Inverse S-box: inverse affine transform followed by field inverse
module inv_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);
   import sub_bytes_pkg::*;
   logic [7:0] t;
   assign t   = rotl(a_i, 1) ^ rotl(a_i, 3) ^ rotl(a_i, 6) ^ 8'h05;
   assign y_o = gf_inv(t);
endmodule

module sub_bytes_iter #(
   parameter int BLOCK_BYTES = 16,
   parameter int LANES       = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [0:8*BLOCK_BYTES-1]   in_data,
   input  logic                       in_inv,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [0:8*BLOCK_BYTES-1]   out_data
);
   localparam int NBEATS = BLOCK_BYTES / LANES;
   localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [BW-1:0] LAST = BW'(NBEATS - 1);

   if (BLOCK_BYTES < 1 || LANES < 1 || (BLOCK_BYTES % LANES) != 0) begin : g_bad_cfg
      $error("sub_bytes_iter: BLOCK_BYTES must be a positive multiple of LANES");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // State held as [beat][lane][byte] so each beat selects one lane group
   typedef logic [NBEATS-1:0][LANES-1:0][7:0] blk_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic            mode_q, mode_d;
   blk_t            src_q, src_d, res_q, res_d, in_arr;
   logic [LANES-1:0][7:0] fwd_y, inv_y, lane_y;

   // Byte i of the flat bus lands at beat i/LANES, lane i%LANES
   for (genvar i = 0; i < BLOCK_BYTES; i++) begin : g_map
      assign in_arr[i / LANES][i % LANES]   = in_data[8*i +: 8];
      assign out_data[8*i +: 8]             = res_q[i / LANES][i % LANES];
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      sbox     u_fwd (.a_i(src_q[beat_q][l]), .y_o(fwd_y[l]));
      inv_sbox u_inv (.a_i(src_q[beat_q][l]), .y_o(inv_y[l]));
      assign lane_y[l] = mode_q ? inv_y[l] : fwd_y[l];
   end

   // Next-state, handshake outputs and datapath updates
   always_comb begin
      logic load;
      state_d   = state_q;
      beat_d    = beat_q;
      mode_d    = mode_q;
      src_d     = src_q;
      res_d     = res_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            load     = in_valid;
         end
         RUN: begin
            res_d[beat_q] = lane_y;
            if (beat_q == LAST) state_d = DONE;
            else                beat_d  = beat_q + 1'b1;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               in_ready = 1'b1;
               load     = in_valid;
               if (!in_valid) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         src_d   = in_arr;
         mode_d  = in_inv;
         beat_d  = '0;
         state_d = RUN;
      end
   end

   // State and datapath registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         mode_q  <= 1'b0;
         src_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         mode_q  <= mode_d;
         src_q   <= src_d;
         res_q   <= res_d;
      end
   end
endmodule

// File: tb/tb_sub_bytes_iter.sv
module tb_sub_bytes_iter;
   localparam int NB = 4;  // beats per block for the main instance

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b1;
   logic [0:127] in_data = '0;
   logic in_ready, out_valid;
   logic [0:127] out_data;

   logic a_valid = 1'b0, a_inv = 1'b0, one = 1'b1;
   logic [0:127] a_data = '0;
   logic a1_rdy, a1_ov, a16_rdy, a16_ov;
   logic [0:127] a1_od, a16_od;

   always #5 clk = ~clk;

   sub_bytes_iter #(.BLOCK_BYTES(16), .LANES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));
   sub_bytes_iter #(.BLOCK_BYTES(16), .LANES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a1_rdy), .in_data(a_data),
      .in_inv(a_inv), .out_valid(a1_ov), .out_ready(one), .out_data(a1_od));
   sub_bytes_iter #(.BLOCK_BYTES(16), .LANES(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a16_rdy), .in_data(a_data),
      .in_inv(a_inv), .out_valid(a16_ov), .out_ready(one), .out_data(a16_od));

   // FIPS-197 forward S-box
   logic [7:0] fwd_tab [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
   logic [7:0] inv_tab [256];

   int n_checks = 0, n_fail = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [0:127] model(input logic [0:127] d, input logic inv);
      logic [0:127] r;
      for (int i = 0; i < 16; i++)
         r[8*i +: 8] = inv ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
      return r;
   endfunction

   // Transaction-level reference: one block in flight, done NB cycles after accept
   int cyc = 0, done_at = 0;
   bit have_blk = 0, chk_en = 0;
   logic [0:127] exp_res = '0;
   int out_cyc[$];

   always @(posedge clk) begin
      bit ov, ir;
      ov = have_blk && (cyc >= done_at);
      ir = !have_blk || (ov && out_ready);
      cyc++;
      if (rst) have_blk = 0;
      else begin
         if (ov && out_ready) begin
            have_blk = 0;
            out_cyc.push_back(cyc);
         end
         if (in_valid && ir) begin
            have_blk = 1;
            done_at  = cyc + NB;
            exp_res  = model(in_data, in_inv);
         end
      end
   end

   // Compare the main instance against the reference every cycle
   always @(negedge clk) begin
      bit ov;
      if (chk_en && !rst) begin
         ov = have_blk && (cyc >= done_at);
         chk("out_valid", 128'(out_valid), 128'(ov));
         chk("in_ready", 128'(in_ready), 128'(!have_blk || (ov && out_ready)));
         if (ov) chk("out_data", out_data, exp_res);
      end
   end

   task automatic send(input logic [0:127] d, input logic inv);
      int n = 0;
      in_valid = 1'b1; in_data = d; in_inv = inv;
      @(negedge clk);
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      if (!in_ready) chk("send_timeout", 128'(in_ready), 128'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 64) begin @(posedge clk); #1; n++; end
      if (!out_valid) chk("valid_timeout", 128'(out_valid), 128'(1));
   endtask

   localparam logic [0:127] D0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [0:127] D1 = 128'h637c777bf26b6fc53001672bfed7ab76;

   initial begin
      int n, n1, n16, held_n;
      logic [0:127] held, rd;
      for (int v = 0; v < 256; v++) inv_tab[fwd_tab[v]] = 8'(v);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0; chk_en = 1;
      @(negedge clk);
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_data", out_data, 128'(0));

      // Pin the reference against literal vectors
      chk("model_fwd", model(D0, 1'b0), D1);
      chk("model_inv", model(D1, 1'b1), D0);
      chk("model_53", 128'(fwd_tab[8'h53]), 128'(8'hed));

      // Directed forward and inverse, 4 lanes
      @(posedge clk); #1;
      send(D0, 1'b0); wait_valid(n);
      chk("lat_fwd", 128'(n), 128'(NB));
      chk("data_fwd", out_data, D1);
      @(posedge clk); #1;
      send(D1, 1'b1); wait_valid(n);
      chk("lat_inv", 128'(n), 128'(NB));
      chk("data_inv", out_data, D0);
      repeat (3) @(posedge clk); #1;

      // 1-lane and 16-lane instances
      a_valid = 1'b1; a_data = D1; a_inv = 1'b1;
      @(posedge clk); #1;
      a_valid = 1'b0;
      n1 = -1; n16 = -1;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         if (a1_ov && n1 < 0) begin n1 = c; chk("data_l1", a1_od, D0); end
         if (a16_ov && n16 < 0) begin n16 = c; chk("data_l16", a16_od, D0); end
      end
      chk("lat_l1", 128'(n1), 128'(16));
      chk("lat_l16", 128'(n16), 128'(1));

      // Backpressure, then release with a new block in the same cycle
      out_ready = 1'b0;
      rd = {$urandom, $urandom, $urandom, $urandom};
      send(rd, 1'b0); wait_valid(n);
      held = out_data; held_n = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_data === held && in_ready === 1'b0 && out_valid === 1'b1) held_n++;
      end
      chk("bp_stable", 128'(held_n), 128'(10));
      @(posedge clk); #1;
      rd = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1; in_data = rd; in_inv = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_restart_ov", 128'(out_valid), 128'(0));
      wait_valid(n);
      chk("bp_restart_lat", 128'(n), 128'(NB));
      chk("bp_restart_data", out_data, model(rd, 1'b1));
      repeat (4) @(posedge clk); #1;

      // Back-to-back streaming with alternating mode
      out_cyc.delete();
      for (int b = 0; b < 8; b++) send({$urandom, $urandom, $urandom, $urandom}, b[0]);
      repeat (8) @(posedge clk); #1;
      chk("stream_count", 128'(out_cyc.size()), 128'(8));
      for (int b = 1; b < out_cyc.size(); b++)
         chk("stream_gap", 128'(out_cyc[b] - out_cyc[b-1]), 128'(NB + 1));

      // Reset in the middle of a block
      send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
      chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
      chk("mid_rst_out_data", out_data, 128'(0));
      repeat (6) @(posedge clk); #1;
      send(128'(0), 1'b0); wait_valid(n);
      chk("zero_block", out_data, {16{8'h63}});
      @(posedge clk); #1;

      // Mode isolation: in_inv toggles while the block runs
      for (int m = 0; m < 2; m++) begin
         rd = {8'h53, 24'($urandom), $urandom, $urandom, $urandom};
         send(rd, m[0]);
         n = 0;
         while (!out_valid && n < 64) begin in_inv = ~in_inv; @(posedge clk); #1; n++; end
         chk("iso_lat", 128'(n), 128'(NB));
         chk("iso_byte0", 128'(out_data[0:7]), m[0] ? 128'(8'h50) : 128'(8'hed));
         @(posedge clk); #1;
      end

      // Random traffic with random backpressure
      for (int c = 0; c < 400; c++) begin
         in_valid  = 1'($urandom);
         in_inv    = 1'($urandom);
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sub_bytes_iter.md
# sub_bytes_iter

Iterative, parametrised AES SubBytes engine. It substitutes a state of BLOCK_BYTES bytes using LANES S-box lanes per clock, so area trades against latency. A per-block mode bit selects the forward S-box (encrypt) or the inverse S-box (decrypt). Valid/ready handshakes on both sides let it sit between the round-key/ShiftRows stages of a multi-cycle AES round datapath.

## Interface
- BLOCK_BYTES, 16: state size in bytes. Must be ≥1.
- LANES, 4: S-box lanes per cycle. BLOCK_BYTES % LANES must be 0; any other value is an elaboration error.
- NBEATS (localparam) = BLOCK_BYTES/LANES: processing cycles per block.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data and in_inv are valid.
- in_ready  output  1  block can accept a state this cycle.
- in_data  input  [0:8*BLOCK_BYTES-1]  input state. Byte i is in_data[8*i +: 8], so byte 0 holds the MSBs.
- in_inv  input  1  0 selects forward S-box, 1 selects inverse S-box. Captured with in_data.
- out_valid  output  1  out_data holds a completed substituted state.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  [0:8*BLOCK_BYTES-1]  substituted state, same byte ordering as in_data.

## Operation
- Lanes: LANES instances of the existing forward sbox and LANES instances of inv_sbox. The lane result is muxed by the captured mode bit.
- States and transitions:
  - IDLE: in_ready=1. When in_valid=1, capture in_data into the source register and in_inv into the mode register, set beat=0, go to RUN.
  - RUN: in_ready=0, out_valid=0.
    - Each cycle, source bytes beat*LANES .. beat*LANES+LANES-1 go through the lanes and are written to the same byte positions of the result register.
    - If beat==NBEATS-1, go to DONE. Otherwise beat increments.
  - DONE: out_valid=1. out_data is the result register, held stable until accepted.
    - If out_ready=1 and in_valid=1: capture the new block and go to RUN with beat=0 (back-to-back).
    - If out_ready=1 and in_valid=0: go to IDLE.
    - If out_ready=0: stay in DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from out_ready; there is no path from in_valid to in_ready.
- The beat counter is $clog2(NBEATS) bits wide, with a minimum of 1. It never exceeds NBEATS-1 and never wraps within a block.
- Mode is per block. Changing in_inv while the block is not accepting has no effect on the block in flight.
- No partial output is ever exposed. out_data bytes not yet written in the current block are don't-care while out_valid=0.

## Timing
- Reset (rst=1 at a rising edge): state=IDLE, beat=0, mode=0, source and result registers=0. Outputs: in_ready=1 from the cycle after reset, out_valid=0, out_data=0.
- Reset mid-RUN or in DONE aborts the block. No out_valid is produced for it.
- Latency: a block accepted at edge E0 gives out_valid=1 after edge E0+NBEATS. With LANES=BLOCK_BYTES this is 1 cycle.
- Throughput:
  - Sustained with out_ready held at 1: one block per NBEATS+1 cycles, since the DONE cycle overlaps the next accept.
  - With an idle gap in between: NBEATS+2 cycles.
- Backpressure: out_data and out_valid stay constant while out_valid=1 and out_ready=0.
- in_valid may drop while in_ready=0 without effect. The upstream side holds data until in_ready=1 and in_valid=1 coincide.

## Test plan
- Forward, LANES=4, data 000102030405060708090a0b0c0d0e0f, inv=0 → out_valid 4 cycles after accept; out_data 637c777bf26b6fc53001672bfed7ab76.
- Inverse, same config, data 637c777bf26b6fc53001672bfed7ab76, inv=1 → 000102030405060708090a0b0c0d0e0f. Repeat with LANES=1 (16-cycle latency) and LANES=16 (1-cycle latency).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_data stable and in_ready=0 throughout. Asserting out_ready with in_valid=1 must start the next block in the same cycle.
- Back-to-back streaming, out_ready=1: 8 random blocks with alternating inv → exactly one output per 5 cycles (LANES=4), each matching the FIPS-197 table model in order.
- Reset mid-RUN: assert rst at beat 2 → out_valid stays 0, in_ready=1 the next cycle, out_data=0. A following block with data all-00, inv=0 yields all-63.
- Mode isolation: toggle in_inv every cycle during RUN → the result uses only the mode captured at accept. For a single byte 53, forward gives ed.
